// File: rtl/rvj1_timer_pkg.sv
// Shared constants and helpers for the rvj1 Wishbone timer: register word
// offsets, CTRL/STATUS bit positions and the byte-lane write merge.
package rvj1_timer_pkg;

  localparam logic [5:0] OFF_CTRL     = 6'h00;
  localparam logic [5:0] OFF_PRESCALE = 6'h01;
  localparam logic [5:0] OFF_COUNT    = 6'h02;
  localparam logic [5:0] OFF_CMP      = 6'h03;
  localparam logic [5:0] OFF_STATUS   = 6'h04;

  localparam int CTRL_EN         = 0;
  localparam int CTRL_IRQ_EN     = 1;
  localparam int CTRL_AUTORELOAD = 2;

  localparam int STAT_MATCH = 0;
  localparam int STAT_OVF   = 1;

  localparam logic [31:0] CMP_RESET   = 32'hFFFF_FFFF;
  localparam logic [31:0] COUNT_MAX   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic autoreload;
    logic irq_en;
    logic en;
  } ctrl_t;

  // Replace only the byte lanes selected by sel.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) begin
        r[8*b +: 8] = new_v[8*b +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rvj1_wb_timer_if.sv
// Wishbone-classic slave bundle for the rvj1 timer; signal names follow the
// Caravel user-port naming so top-level hookup stays one-to-one.
interface rvj1_wb_timer_if;
  logic        wbs_cyc_i;
  logic        wbs_stb_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_adr_i;
  logic [31:0] wbs_dat_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o
  );
endinterface

// File: rtl/rvj1_timer_prescaler.sv
// Prescaler for the rvj1 timer: divides the clock by (prescale + 1) while
// enabled and emits a single-cycle tick at the terminal count.
module rvj1_timer_prescaler (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] prescale,
  output logic        tick
);

  logic [31:0] pre_cnt_r;
  logic        at_term_s;

  // Terminal-count compare; tick is combinational so the counter advances on
  // the same edge that pre_cnt wraps.
  always_comb begin
    at_term_s = (pre_cnt_r == prescale);
    tick      = en & at_term_s;
  end

  // Divider state: cleared while disabled, wraps to zero at terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_r <= 32'd0;
    end else if (!en) begin
      pre_cnt_r <= 32'd0;
    end else if (at_term_s) begin
      pre_cnt_r <= 32'd0;
    end else begin
      pre_cnt_r <= pre_cnt_r + 32'd1;
    end
  end

endmodule

// File: rtl/rvj1_wb_timer.sv
// rvj1 Wishbone timer: bus decode, register file, 32-bit counter with
// compare/overflow flags and a registered level interrupt.
module rvj1_wb_timer
  import rvj1_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          LA_BITS   = 24
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  rvj1_wb_timer_if.slave     wbs,
  output logic               irq_o,
  output logic [LA_BITS-1:0] count_o
);

  ctrl_t       ctrl_r;
  logic [31:0] prescale_r;
  logic [31:0] count_r;
  logic [31:0] cmp_r;
  logic        match_r;
  logic        ovf_r;
  logic        ack_r;
  logic [31:0] dat_r;
  logic        irq_r;

  logic        hit_s;
  logic        req_s;
  logic        commit_s;
  logic        wr_s;
  logic [5:0]  idx_s;
  logic [31:0] rdata_s;
  logic        tick_s;
  logic        count_wr_s;
  logic        tick_eff_s;
  logic        at_cmp_s;
  logic        at_max_s;
  logic        match_set_s;
  logic        ovf_set_s;
  logic [1:0]  stat_clr_s;
  logic [31:0] count_nxt_s;
  logic        unused_s;

  rvj1_timer_prescaler u_prescaler (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .en       (ctrl_r.en),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // Request decode: a transfer commits on the cycle its ack is registered.
  always_comb begin
    hit_s    = (wbs.wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    req_s    = wbs.wbs_cyc_i & wbs.wbs_stb_i & hit_s;
    commit_s = req_s & ~ack_r;
    wr_s     = commit_s & wbs.wbs_we_i;
    idx_s    = wbs.wbs_adr_i[7:2];
    unused_s = ^wbs.wbs_adr_i[1:0];
  end

  // Read-data mux; unmapped offsets read as zero.
  always_comb begin
    case (idx_s)
      OFF_CTRL:     rdata_s = {29'd0, ctrl_r};
      OFF_PRESCALE: rdata_s = prescale_r;
      OFF_COUNT:    rdata_s = count_r;
      OFF_CMP:      rdata_s = cmp_r;
      OFF_STATUS:   rdata_s = {30'd0, ovf_r, match_r};
      default:      rdata_s = 32'd0;
    endcase
  end

  // Counter next-state; a software COUNT write swallows a coincident tick.
  always_comb begin
    count_wr_s  = wr_s & (idx_s == OFF_COUNT);
    tick_eff_s  = tick_s & ~count_wr_s;
    at_cmp_s    = (count_r == cmp_r);
    at_max_s    = (count_r == COUNT_MAX);
    match_set_s = tick_eff_s & at_cmp_s;
    ovf_set_s   = tick_eff_s & at_max_s;
    if (count_wr_s) begin
      count_nxt_s = byte_merge(count_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
    end else if (tick_eff_s) begin
      if (at_cmp_s && ctrl_r.autoreload) begin
        count_nxt_s = 32'd0;
      end else begin
        count_nxt_s = count_r + 32'd1;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // STATUS write-1-to-clear lanes; only byte 0 carries flags.
  always_comb begin
    if (wr_s && (idx_s == OFF_STATUS) && wbs.wbs_sel_i[0]) begin
      stat_clr_s = wbs.wbs_dat_i[1:0];
    end else begin
      stat_clr_s = 2'b00;
    end
  end

  // Bus response, register file, counter, flags and interrupt state.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ctrl_r     <= ctrl_t'(3'b000);
      prescale_r <= 32'd0;
      count_r    <= 32'd0;
      cmp_r      <= CMP_RESET;
      match_r    <= 1'b0;
      ovf_r      <= 1'b0;
      ack_r      <= 1'b0;
      dat_r      <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      ack_r <= commit_s;
      dat_r <= (commit_s && !wbs.wbs_we_i) ? rdata_s : 32'd0;
      if (wr_s && (idx_s == OFF_CTRL) && wbs.wbs_sel_i[0]) begin
        ctrl_r <= ctrl_t'(wbs.wbs_dat_i[2:0]);
      end
      if (wr_s && (idx_s == OFF_PRESCALE)) begin
        prescale_r <= byte_merge(prescale_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
      if (wr_s && (idx_s == OFF_CMP)) begin
        cmp_r <= byte_merge(cmp_r, wbs.wbs_dat_i, wbs.wbs_sel_i);
      end
      count_r <= count_nxt_s;
      // A same-cycle hardware set beats the clear.
      match_r <= match_set_s | (match_r & ~stat_clr_s[STAT_MATCH]);
      ovf_r   <= ovf_set_s   | (ovf_r   & ~stat_clr_s[STAT_OVF]);
      irq_r   <= ctrl_r.irq_en & (match_r | ovf_r);
    end
  end

  assign wbs.wbs_ack_o = ack_r;
  assign wbs.wbs_dat_o = dat_r;
  assign irq_o         = irq_r;
  assign count_o       = count_r[LA_BITS-1:0];

endmodule

// File: tb/tb_rvj1_wb_timer.sv
// Directed plus randomized bench for rvj1_wb_timer with a behavioural model.
module tb_rvj1_wb_timer;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        irq;
  logic [23:0] cnt_la;

  int          total = 0;
  int          bad   = 0;
  int unsigned edge_n = 0;
  int unsigned commit_edge = 0;

  rvj1_wb_timer_if bus ();

  rvj1_wb_timer #(.BASE_ADDR(BASE), .LA_BITS(24)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs      (bus),
    .irq_o    (irq),
    .count_o  (cnt_la)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One classic transfer; lat is the ack latency in cycles or -1 on timeout.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdat, output int lat);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
    bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
    lat = -1; rdat = 32'hDEAD_BEEF;
    for (int i = 1; i <= 6 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (bus.wbs_ack_o === 1'b1) begin
        lat = i; rdat = bus.wbs_dat_o; commit_edge = edge_n;
      end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] d; int lat;
    xfer(1'b1, BASE + {24'd0, off}, dat, sel, d, lat);
    chk("wr_ack_latency", lat, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] d; int lat;
    xfer(1'b0, BASE + {24'd0, off}, 32'd0, 4'hF, d, lat);
    chk("rd_ack_latency", lat, 32'd1);
    chk(tag, d, exp);
  endtask

  initial begin
    logic [31:0] m_reg [0:3];
    logic [31:0] d, exp, c0;
    int          lat, w, p, k;
    int unsigned e1, dn;
    logic [3:0]  sel;
    logic        we;

    rst = 1'b1;
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'd0; bus.wbs_dat_i = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_dat", bus.wbs_dat_o, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_count_o", {8'd0, cnt_la}, 32'd0);
    rst = 1'b0;

    rd_chk("rst_ctrl", 8'h00, 32'd0);
    rd_chk("rst_prescale", 8'h04, 32'd0);
    rd_chk("rst_count", 8'h08, 32'd0);
    rd_chk("rst_cmp", 8'h0C, 32'hFFFF_FFFF);
    rd_chk("rst_status", 8'h10, 32'd0);
    @(posedge clk); #1;
    chk("ack_one_wide", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("rst_irq_after", {31'd0, irq}, 32'd0);

    // Held request: ack toggles every other cycle.
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
    bus.wbs_adr_i = BASE + 32'h0C; bus.wbs_sel_i = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      chk("b2b_ack", {31'd0, bus.wbs_ack_o}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("b2b_dat", bus.wbs_dat_o, (i % 2 == 1) ? 32'hFFFF_FFFF : 32'd0);
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;

    xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, d, lat);
    chk("nohit_ack", lat, 32'hFFFF_FFFF);
    xfer(1'b1, 32'h2000_0008, 32'h55, 4'hF, d, lat);
    chk("nohit_wr_ack", lat, 32'hFFFF_FFFF);
    rd_chk("nohit_wr_ignored", 8'h08, 32'd0);

    // Random register traffic with the timer stopped.
    m_reg[0] = 32'd0; m_reg[1] = 32'd0; m_reg[2] = 32'd0; m_reg[3] = 32'hFFFF_FFFF;
    for (int i = 0; i < 24; i++) begin
      w   = $urandom_range(0, 9);
      if (w > 4) w = $urandom_range(5, 63);
      we  = 1'($urandom_range(0, 1));
      d   = $urandom;
      sel = 4'($urandom_range(0, 15));
      if (w == 0) d[0] = 1'b0;
      if (we) begin
        wr(8'(w * 4), d, sel);
        if (w == 0 && sel[0]) m_reg[0] = {29'd0, d[2:0]};
        if (w >= 1 && w <= 3) begin
          for (int b = 0; b < 4; b++) if (sel[b]) m_reg[w][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        exp = (w <= 3) ? m_reg[w] : 32'd0;
        rd_chk("rand_rd", 8'(w * 4), exp);
      end
    end
    for (int r = 0; r < 4; r++) rd_chk("rand_final", 8'(r * 4), m_reg[r]);
    chk("rand_irq", {31'd0, irq}, 32'd0);

    // Free run: ticks come every (P+1) enabled edges.
    wr(8'h00, 32'd0, 4'hF); wr(8'h0C, 32'hFFFF_FFFF, 4'hF); wr(8'h10, 32'd3, 4'hF);
    wr(8'h04, 32'd3, 4'hF); wr(8'h08, 32'd0, 4'hF);
    wr(8'h00, 32'd1, 4'hF); e1 = commit_edge;
    repeat (38) @(posedge clk);
    wr(8'h00, 32'd0, 4'hF); dn = commit_edge;
    rd_chk("freerun_p3", 8'h08, (dn - e1) / 4);
    for (int i = 0; i < 4; i++) begin
      p  = $urandom_range(0, 6);
      k  = $urandom_range(5, 40);
      c0 = $urandom;
      wr(8'h04, p, 4'hF); wr(8'h08, c0, 4'hF);
      wr(8'h00, 32'd1, 4'hF); e1 = commit_edge;
      repeat (k) @(posedge clk);
      wr(8'h00, 32'd0, 4'hF); dn = commit_edge;
      rd_chk("freerun_rand", 8'h08, c0 + (dn - e1) / (p + 1));
    end

    // Compare with autoreload: sequence 0..5 repeating, irq one cycle behind MATCH.
    wr(8'h08, 32'd0, 4'hF); wr(8'h0C, 32'd5, 4'hF); wr(8'h04, 32'd0, 4'hF);
    wr(8'h10, 32'd3, 4'hF);
    wr(8'h00, 32'd7, 4'hF);
    for (int j = 1; j <= 14; j++) begin
      @(posedge clk); #1;
      chk("autoreload_cnt", {8'd0, cnt_la}, j % 6);
      chk("autoreload_irq", {31'd0, irq}, (j >= 7) ? 32'd1 : 32'd0);
    end
    wr(8'h00, 32'd2, 4'hF);
    rd_chk("match_status", 8'h10, 32'd1);
    chk("match_irq_held", {31'd0, irq}, 32'd1);
    wr(8'h10, 32'd1, 4'h1);
    @(posedge clk); #1;
    chk("w1c_irq_low", {31'd0, irq}, 32'd0);
    rd_chk("w1c_status", 8'h10, 32'd0);

    // Overflow with CMP at its reset value.
    wr(8'h00, 32'd0, 4'hF); wr(8'h0C, 32'hFFFF_FFFF, 4'hF); wr(8'h10, 32'd3, 4'hF);
    wr(8'h08, 32'hFFFF_FFFE, 4'hF);
    wr(8'h00, 32'd1, 4'hF); e1 = commit_edge;
    @(posedge clk); #1;
    chk("ovf_cnt1", {8'd0, cnt_la}, 32'h00FF_FFFF);
    @(posedge clk); #1;
    chk("ovf_cnt2", {8'd0, cnt_la}, 32'd0);
    wr(8'h00, 32'd0, 4'hF); dn = commit_edge;
    rd_chk("ovf_count", 8'h08, 32'hFFFF_FFFE + (dn - e1));
    rd_chk("ovf_status", 8'h10, 32'd3);
    chk("ovf_no_irq", {31'd0, irq}, 32'd0);

    // COUNT write coinciding with a tick wins.
    wr(8'h10, 32'd3, 4'hF);
    wr(8'h00, 32'd1, 4'hF);
    wr(8'h08, 32'h100, 4'hF);
    chk("cnt_wr_wins", {8'd0, cnt_la}, 32'h100);
    @(posedge clk); #1;
    chk("cnt_wr_next", {8'd0, cnt_la}, 32'h101);
    wr(8'h00, 32'd0, 4'hF);

    // MATCH set coinciding with its W1C stays set.
    wr(8'h08, 32'd0, 4'hF); wr(8'h0C, 32'd1, 4'hF); wr(8'h10, 32'd3, 4'hF);
    wr(8'h00, 32'd1, 4'hF);
    wr(8'h10, 32'd1, 4'hF);
    wr(8'h00, 32'd0, 4'hF);
    rd_chk("w1c_collide", 8'h10, 32'd1);

    // Byte-lane write.
    wr(8'h0C, 32'd0, 4'hF);
    wr(8'h0C, 32'h1234_AB78, 4'b0010);
    rd_chk("byte_write_cmp", 8'h0C, 32'h0000_AB00);

    // Reset during an in-flight write.
    wr(8'h08, 32'h1234, 4'hF);
    chk("pre_rst_cnt", {8'd0, cnt_la}, 32'h1234);
    @(posedge clk); #1;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
    bus.wbs_adr_i = BASE + 32'h08; bus.wbs_dat_i = 32'h5555; bus.wbs_sel_i = 4'hF;
    #2 rst = 1'b1;
    #1;
    chk("midrst_ack", {31'd0, bus.wbs_ack_o}, 32'd0);
    chk("midrst_cnt", {8'd0, cnt_la}, 32'd0);
    @(posedge clk); #1;
    chk("midrst_ack_hold", {31'd0, bus.wbs_ack_o}, 32'd0);
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_idle_cnt", {8'd0, cnt_la}, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);
    rd_chk("post_rst_count", 8'h08, 32'd0);
    rd_chk("post_rst_ctrl", 8'h00, 32'd0);
    rd_chk("post_rst_cmp", 8'h0C, 32'hFFFF_FFFF);
    rd_chk("post_rst_status", 8'h10, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
